// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared types and constants for the calculator sequencer
package calc_pkg;

    localparam int DATA_W = 6;
    localparam int OP_W   = 2;

    localparam logic [1:0] PH_A   = 2'b00;
    localparam logic [1:0] PH_B   = 2'b01;
    localparam logic [1:0] PH_RUN = 2'b10;
    localparam logic [1:0] PH_ERR = 2'b11;

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_EXEC,
        S_SHOW,
        S_ERR
    } state_t;

    function automatic logic [1:0] phase_of(input state_t s);
        case (s)
            S_A:            return PH_A;
            S_B:            return PH_B;
            S_EXEC, S_SHOW: return PH_RUN;
            default:        return PH_ERR;
        endcase
    endfunction

endpackage

// File: rtl/calc_sequencer_btn.sv
// rtl/calc_sequencer_btn.sv - button synchroniser, debouncer and press-pulse generator
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_d;
    logic             r_press;
    logic             r_armed;
    logic [1:0]       r_warm;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_press   <= 1'b0;
            r_armed   <= 1'b0;
            r_warm    <= 2'b00;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn;
            r_sync2   <= r_sync1;
            r_warm    <= {r_warm[0], 1'b1};
            // A button held through reset must be seen released before it can press.
            r_armed   <= r_armed | (r_warm[1] & ~r_sync2);
            r_level_d <= r_level;
            r_press   <= r_level & ~r_level_d & r_armed;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_LAST) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/calc_sequencer.sv
// rtl/calc_sequencer.sv - operand entry, ALU handshake and display sequencing for the calculator
module calc_sequencer
    import calc_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int ALU_TIMEOUT     = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw_value,
    input  logic [OP_W-1:0]   sw_op,
    input  logic              btn_enter,
    input  logic              btn_mode,
    input  logic              btn_clear,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    output logic              alu_start,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_valid,
    input  logic              alu_overflow,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_mode,
    output logic [1:0]        phase,
    output logic              err
);

    localparam int             TMR_W    = $clog2(ALU_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_END = TMR_W'(ALU_TIMEOUT);

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [OP_W-1:0]   r_op;
    logic [DATA_W-1:0] r_res;
    logic [TMR_W-1:0]  r_timer;
    logic              r_start;
    logic [DATA_W-1:0] r_disp;
    logic              r_mode;
    logic              w_enter;
    logic              w_mode_p;
    logic              w_clear;
    logic [1:0]        w_phase;
    logic              w_err;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_enter), .o_press(w_enter)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_mode), .o_press(w_mode_p)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear (
        .clk(clk), .rst_n(rst_n), .i_btn(btn_clear), .o_press(w_clear)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (w_clear) begin
            w_next_state = S_A;
        end else begin
            case (r_state)
                S_A:    if (w_enter) w_next_state = S_B;
                S_B:    if (w_enter) w_next_state = S_EXEC;
                S_EXEC: begin
                    if (alu_valid) begin
                        w_next_state = alu_overflow ? S_ERR : S_SHOW;
                    end else if (r_timer == TMR_END) begin
                        w_next_state = S_ERR;
                    end
                end
                S_SHOW: if (w_enter) w_next_state = S_B;
                S_ERR:  w_next_state = S_ERR;
                default: w_next_state = S_A;
            endcase
        end
    end

    always_comb begin
        w_phase = phase_of(r_state);
        w_err   = (r_state == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_res   <= '0;
            r_timer <= '0;
            r_start <= 1'b0;
            r_disp  <= '0;
            r_mode  <= 1'b0;
        end else begin
            r_start <= (r_state == S_B) && w_enter && !w_clear;
            if (w_mode_p) begin
                r_mode <= ~r_mode;
            end
            if (w_clear) begin
                r_a     <= '0;
                r_b     <= '0;
                r_op    <= '0;
                r_res   <= '0;
                r_timer <= '0;
            end else begin
                case (r_state)
                    S_A: if (w_enter) r_a <= sw_value;
                    S_B: begin
                        if (w_enter) begin
                            r_b     <= sw_value;
                            r_op    <= sw_op;
                            r_timer <= '0;
                        end
                    end
                    S_EXEC: begin
                        if (alu_valid) begin
                            r_res <= alu_result;
                        end else if (r_timer != TMR_END) begin
                            r_timer <= r_timer + 1'b1;
                        end
                    end
                    S_SHOW: if (w_enter) r_a <= r_res;
                    default: ;
                endcase
            end
            // Display follows the state being entered so it lines up with phase.
            case (w_next_state)
                S_A, S_B: r_disp <= sw_value;
                S_SHOW:   r_disp <= (r_state == S_SHOW) ? r_res : alu_result;
                S_ERR:    r_disp <= '0;
                default:  r_disp <= r_disp;
            endcase
        end
    end

    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign alu_op    = r_op;
    assign alu_start = r_start;
    assign disp_data = r_disp;
    assign disp_mode = r_mode;
    assign phase     = w_phase;
    assign err       = w_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb/tb_calc_sequencer.sv - self-checking bench for calc_sequencer
module tb_calc_sequencer;

    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [5:0] sw_value;
    logic [1:0]        sw_op;
    logic              btn_enter, btn_mode, btn_clear;
    logic [5:0]        alu_a, alu_b;
    logic [1:0]        alu_op;
    logic              alu_start;
    logic [5:0]        alu_result;
    logic              alu_valid;
    logic              alu_overflow;
    logic [5:0]        disp_data;
    logic              disp_mode;
    logic [1:0]        phase;
    logic              err;

    int n_checks = 0;
    int n_fail   = 0;

    // 0 = normal ALU, 1 = always flag overflow, 2 = never respond
    int alu_mode = 0;
    int alu_cnt  = 0;
    int cap_a, cap_b, cap_op, alu_r;

    localparam logic [2:0] BTN_E = 3'b001;
    localparam logic [2:0] BTN_M = 3'b010;
    localparam logic [2:0] BTN_C = 3'b100;

    calc_sequencer #(.DEBOUNCE_CYCLES(4), .ALU_TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n), .sw_value(sw_value), .sw_op(sw_op),
        .btn_enter(btn_enter), .btn_mode(btn_mode), .btn_clear(btn_clear),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_start(alu_start),
        .alu_result(alu_result), .alu_valid(alu_valid), .alu_overflow(alu_overflow),
        .disp_data(disp_data), .disp_mode(disp_mode), .phase(phase), .err(err)
    );

    always #5 clk = ~clk;

    function automatic int calc(input int op, input int a, input int b);
        case (op)
            0:       return a + b;
            1:       return a - b;
            2:       return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic bit ovf(input int op, input int r);
        return (op < 2) && (r > 31 || r < -32);
    endfunction

    // ALU with a fixed two-cycle latency from start to valid
    initial begin
        alu_valid = 1'b0;
        alu_overflow = 1'b0;
        alu_result = '0;
        forever begin
            @(posedge clk);
            #1;
            alu_valid = 1'b0;
            alu_overflow = 1'b0;
            if (alu_cnt > 0) begin
                alu_cnt--;
                if (alu_cnt == 0 && alu_mode != 2) begin
                    alu_r = calc(cap_op, cap_a, cap_b);
                    alu_result = alu_r[5:0];
                    alu_valid = 1'b1;
                    alu_overflow = (alu_mode == 1) || ovf(cap_op, alu_r);
                end
            end
            if (alu_start) begin
                alu_cnt = 2;
                cap_a = $signed(alu_a);
                cap_b = $signed(alu_b);
                cap_op = int'(alu_op);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] m);
        btn_enter = m[0];
        btn_mode  = m[1];
        btn_clear = m[2];
        step(8);
        btn_enter = 1'b0;
        btn_mode  = 1'b0;
        btn_clear = 1'b0;
        step(20);
    endtask

    typedef struct {
        logic [2:0]        btn;
        logic signed [5:0] sw;
        logic [1:0]        op;
        int                amode;
        logic [1:0]        e_ph;
        logic              e_err;
        logic signed [5:0] e_disp;
        logic signed [5:0] e_a;
        logic signed [5:0] e_b;
        logic [1:0]        e_op;
        logic              e_mode;
    } vec_t;

    vec_t tbl[14];

    int                m_ph;
    logic signed [5:0] m_a, m_b, m_res;
    logic [1:0]        m_op;
    logic              m_mode;
    int                r;
    logic signed [5:0] rsw;
    logic [1:0]        rop;
    logic signed [5:0] exp_disp;

    initial begin
        tbl[0]  = '{BTN_E,         6'sd5,  2'd0, 0, 2'b01, 1'b0, 6'sd5,   6'sd5,   6'sd0,   2'd0, 1'b0};
        tbl[1]  = '{BTN_E,        -6'sd3,  2'd0, 0, 2'b10, 1'b0, 6'sd2,   6'sd5,  -6'sd3,   2'd0, 1'b0};
        tbl[2]  = '{BTN_E,         6'sd7,  2'd0, 0, 2'b01, 1'b0, 6'sd7,   6'sd2,  -6'sd3,   2'd0, 1'b0};
        tbl[3]  = '{BTN_E,         6'sd7,  2'd0, 0, 2'b10, 1'b0, 6'sd9,   6'sd2,   6'sd7,   2'd0, 1'b0};
        tbl[4]  = '{BTN_C | BTN_E, 6'sd7,  2'd0, 0, 2'b00, 1'b0, 6'sd7,   6'sd0,   6'sd0,   2'd0, 1'b0};
        tbl[5]  = '{BTN_M,         6'sd7,  2'd0, 0, 2'b00, 1'b0, 6'sd7,   6'sd0,   6'sd0,   2'd0, 1'b1};
        tbl[6]  = '{BTN_E,         6'sd31, 2'd0, 0, 2'b01, 1'b0, 6'sd31,  6'sd31,  6'sd0,   2'd0, 1'b1};
        tbl[7]  = '{BTN_E,         6'sd1,  2'd0, 0, 2'b11, 1'b1, 6'sd0,   6'sd31,  6'sd1,   2'd0, 1'b1};
        tbl[8]  = '{BTN_M,         6'sd1,  2'd0, 0, 2'b11, 1'b1, 6'sd0,   6'sd31,  6'sd1,   2'd0, 1'b0};
        tbl[9]  = '{BTN_E,         6'sd3,  2'd2, 0, 2'b11, 1'b1, 6'sd0,   6'sd31,  6'sd1,   2'd0, 1'b0};
        tbl[10] = '{BTN_C,        -6'sd1,  2'd0, 0, 2'b00, 1'b0, -6'sd1,  6'sd0,   6'sd0,   2'd0, 1'b0};
        tbl[11] = '{BTN_E,        -6'sd20, 2'd1, 0, 2'b01, 1'b0, -6'sd20, -6'sd20, 6'sd0,   2'd0, 1'b0};
        tbl[12] = '{BTN_E,         6'sd20, 2'd1, 1, 2'b11, 1'b1, 6'sd0,   -6'sd20, 6'sd20,  2'd1, 1'b0};
        tbl[13] = '{BTN_C,         6'sd0,  2'd0, 0, 2'b00, 1'b0, 6'sd0,   6'sd0,   6'sd0,   2'd0, 1'b0};

        rst_n = 1'b0;
        sw_value = '0;
        sw_op = '0;
        btn_enter = 1'b0;
        btn_mode = 1'b0;
        btn_clear = 1'b0;
        step(3);
        check("reset_phase", phase, 0);
        check("reset_err", err, 0);
        check("reset_disp", $signed(disp_data), 0);
        check("reset_a", $signed(alu_a), 0);
        check("reset_start", alu_start, 0);
        check("reset_mode", disp_mode, 0);
        rst_n = 1'b1;
        step(8);

        for (int i = 0; i < 14; i++) begin
            sw_value = tbl[i].sw;
            sw_op = tbl[i].op;
            alu_mode = tbl[i].amode;
            press(tbl[i].btn);
            check($sformatf("vec%0d_phase", i), phase, tbl[i].e_ph);
            check($sformatf("vec%0d_err", i), err, tbl[i].e_err);
            check($sformatf("vec%0d_disp", i), $signed(disp_data), tbl[i].e_disp);
            check($sformatf("vec%0d_a", i), $signed(alu_a), tbl[i].e_a);
            check($sformatf("vec%0d_b", i), $signed(alu_b), tbl[i].e_b);
            check($sformatf("vec%0d_op", i), alu_op, tbl[i].e_op);
            check($sformatf("vec%0d_mode", i), disp_mode, tbl[i].e_mode);
        end
        alu_mode = 0;

        // bouncing enter: one press, 7 cycles after the last rising edge
        sw_value = 6'sd10;
        sw_op = 2'd0;
        btn_enter = 1'b1; step(2);
        btn_enter = 1'b0; step(2);
        btn_enter = 1'b1;
        step(7);
        check("bounce_pre_phase", phase, 0);
        step(1);
        check("bounce_phase", phase, 1);
        check("bounce_a", $signed(alu_a), 10);
        step(2);
        btn_enter = 1'b0;
        step(12);
        check("bounce_norepeat", phase, 1);

        // start pulse width and valid-to-display latency
        sw_value = 6'sd4;
        btn_enter = 1'b1;
        step(7);
        check("start_before", alu_start, 0);
        step(1);
        check("start_high", alu_start, 1);
        check("start_phase", phase, 2);
        check("start_b", $signed(alu_b), 4);
        step(1);
        check("start_low", alu_start, 0);
        step(1);
        check("exec_hold_disp", $signed(disp_data), 4);
        step(1);
        check("valid_disp", $signed(disp_data), 14);
        check("valid_phase", phase, 2);
        btn_enter = 1'b0;
        step(10);

        // timeout with a silent ALU
        press(BTN_C);
        sw_value = 6'sd1;
        press(BTN_E);
        alu_mode = 2;
        btn_enter = 1'b1;
        step(23);
        check("timeout_pre_err", err, 0);
        check("timeout_pre_phase", phase, 2);
        step(1);
        check("timeout_err", err, 1);
        check("timeout_phase", phase, 3);
        check("timeout_disp", $signed(disp_data), 0);
        btn_enter = 1'b0;
        step(10);
        alu_mode = 0;

        // mode in ERR, clear keeps mode, then reset while EXEC waits
        press(BTN_M);
        check("err_mode_toggle", disp_mode, 1);
        press(BTN_C);
        check("clear_keeps_mode", disp_mode, 1);
        sw_value = 6'sd6;
        press(BTN_E);
        sw_value = 6'sd2;
        sw_op = 2'd3;
        btn_enter = 1'b1;
        step(8);
        check("rst_exec_start", alu_start, 1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check("rst_phase", phase, 0);
        check("rst_err", err, 0);
        check("rst_disp", $signed(disp_data), 0);
        check("rst_a", $signed(alu_a), 0);
        check("rst_b", $signed(alu_b), 0);
        check("rst_op", alu_op, 0);
        check("rst_start", alu_start, 0);
        check("rst_mode", disp_mode, 0);
        step(9);
        btn_enter = 1'b0;
        step(10);
        check("late_valid_phase", phase, 0);
        check("late_valid_a", $signed(alu_a), 0);
        check("late_valid_disp", $signed(disp_data), 2);

        // random button sequences against a transaction-level calculator model
        m_ph = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_mode = 0;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            rsw = 6'($urandom_range(0, 63));
            rop = 2'($urandom_range(0, 3));
            sw_value = rsw;
            sw_op = rop;
            if (r <= 6) begin
                press(BTN_E);
                if (m_ph == 0) begin
                    m_a = rsw;
                    m_ph = 1;
                end else if (m_ph == 1) begin
                    int res;
                    m_b = rsw;
                    m_op = rop;
                    res = calc(int'(rop), int'(m_a), int'(rsw));
                    m_res = res[5:0];
                    m_ph = ovf(int'(rop), res) ? 3 : 2;
                end else if (m_ph == 2) begin
                    m_a = m_res;
                    m_ph = 1;
                end
            end else if (r == 7) begin
                press(BTN_M);
                m_mode = ~m_mode;
            end else begin
                press(BTN_C);
                m_ph = 0; m_a = 0; m_b = 0; m_op = 0; m_res = 0;
            end
            exp_disp = (m_ph <= 1) ? rsw : (m_ph == 2) ? m_res : 6'sd0;
            check($sformatf("rnd%0d_phase", k), phase, m_ph);
            check($sformatf("rnd%0d_err", k), err, (m_ph == 3) ? 1 : 0);
            check($sformatf("rnd%0d_disp", k), $signed(disp_data), exp_disp);
            check($sformatf("rnd%0d_a", k), $signed(alu_a), m_a);
            check($sformatf("rnd%0d_b", k), $signed(alu_b), m_b);
            check($sformatf("rnd%0d_op", k), alu_op, m_op);
            check($sformatf("rnd%0d_mode", k), disp_mode, m_mode);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Top-level controller for the calculator datapath. Debounces the three user buttons and sequences operand entry, ALU operation and result display. Latches operand A, operand B and the opcode from the board switches, issues a one-cycle start to the ALU and waits for its result with a timeout. Drives the signed value and decimal/hex mode consumed by the 7-segment display driver.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required before a button level is accepted (10 ms at 100 MHz).
- `ALU_TIMEOUT`, 15: cycles allowed in EXEC without `alu_valid` before error.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `sw_value`  in  6  signed operand from switches.
- `sw_op`  in  2  operation select, passed to ALU unmodified.
- `btn_enter`, `btn_mode`, `btn_clear`  in  1 each  raw asynchronous buttons, active-high.
- `alu_a`, `alu_b`  out  6  signed operand registers.
- `alu_op`  out  2  latched opcode.
- `alu_start`  out  1  one-cycle start pulse.
- `alu_result`  in  6  signed ALU result.
- `alu_valid`  in  1  result qualifier.
- `alu_overflow`  in  1  result out of 6-bit signed range; sampled with `alu_valid`.
- `disp_data`  out  6  signed value to display.
- `disp_mode`  out  1  0 = decimal, 1 = hex.
- `phase`  out  2  A = 00, B = 01, EXEC/SHOW = 10, ERR = 11.
- `err`  out  1  high in ERR.

## Operation
- **Button conditioning.** Each button passes through:
  - a 2-FF synchroniser;
  - a debouncer: the accepted level changes only after the synchronised input differs from it for `DEBOUNCE_CYCLES` consecutive cycles, and any bounce restarts the count;
  - a rising-edge detector on the accepted level, which produces a one-cycle press pulse.
  - Only press pulses are used below.
- **FSM states:** S_A, S_B, S_EXEC, S_SHOW, S_ERR.
- **S_A:**
  - `disp_data` = `sw_value`, registered.
  - Enter: `a_reg` <= `sw_value`, go to S_B.
- **S_B:**
  - `disp_data` = `sw_value`.
  - Enter: `b_reg` <= `sw_value`, `op_reg` <= `sw_op`, `alu_start` <= 1 for exactly one cycle, timer <= 0, go to S_EXEC.
- **S_EXEC:**
  - `disp_data` holds its last value. Enter is ignored.
  - `alu_valid` is sampled every cycle, including the first cycle, when `alu_start` is high.
  - On valid: `res_reg` <= `alu_result`. If `alu_overflow`, go to S_ERR; otherwise go to S_SHOW.
  - Timer increments each cycle without valid. When the timer reaches `ALU_TIMEOUT`, go to S_ERR.
- **S_SHOW:**
  - `disp_data` = `res_reg`.
  - Enter: `a_reg` <= `res_reg` (chained calculation), go to S_B.
- **S_ERR:**
  - `disp_data` = 0, `err` = 1. Enter is ignored.
- **Clear**, any state: go to S_A. `a_reg`, `b_reg`, `op_reg`, `res_reg` and the timer all <= 0. Clear beats enter in the same cycle.
- **Mode**, any state including ERR: toggles `disp_mode`. Clear does not change `disp_mode`.
- `alu_a`/`alu_b`/`alu_op` are driven continuously from `a_reg`/`b_reg`/`op_reg`.
- All values are 6-bit two's complement. No arithmetic is done in this block.

## Timing
- **Reset** (`rst_n` low at a `clk` edge):
  - state S_A;
  - all registers, `alu_start`, `disp_data`, `disp_mode` and `err` = 0; `phase` = 00;
  - synchronisers and debouncers cleared, accepted levels = 0, so a button held through reset produces no press;
  - reset mid-EXEC drops the pending operation, and a late `alu_valid` is ignored.
- **Press latency:** a clean edge on a raw button produces its pulse 2 + `DEBOUNCE_CYCLES` + 1 cycles later.
- **Enter to outputs:** the enter pulse in cycle N gives a state change and register update visible in cycle N+1. `alu_start` is high in cycle N+1 only.
- **Valid to display:** `alu_valid` in cycle M gives `disp_data` = result and `phase` updated in cycle M+1.
- **Timeout:** with no valid, `err` rises in cycle N+1+`ALU_TIMEOUT`+1.
- **Wrap-around:** the debounce counter saturates, so a level held indefinitely produces no repeat pulse. The timer never wraps.

## Structure
- **Package `calc_pkg`:**
  - `state_t` enum (S_A, S_B, S_EXEC, S_SHOW, S_ERR);
  - `DATA_W` = 6, `OP_W` = 2;
  - `phase` encodings.
- **Sub-module `btn_debounce`** (synchroniser + debouncer + edge pulse, parameter `DEBOUNCE_CYCLES`), instantiated three times.
- The FSM, datapath registers and timer live in `calc_sequencer`.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4 and a bench ALU model with latency 2.
- **Basic add:** `sw_value` = 5 + enter, then `sw_value` = -3 + enter, `sw_op` = 0.
  - `alu_start` one cycle; `alu_a` = 5, `alu_b` = -3 (6'b111101); after valid `disp_data` = 2, `phase` = 10.
- **Bounce:** raw enter toggles 1/0/1 at 2-cycle spacing, then holds high 10 cycles.
  - Exactly one press pulse, 7 cycles after the final rising edge. No repeat while held.
- **Chaining:** in SHOW with result 2, press enter, then enter 7 as B.
  - `alu_a` = 2, `alu_b` = 7, new start pulse.
- **Overflow and timeout:**
  - ALU returns valid with overflow → `err` = 1, `disp_data` = 0, `phase` = 11.
  - Separately, ALU never valid → `err` rises exactly 17 cycles after the enter pulse.
- **Clear/enter collision in SHOW:** clear and enter pulses in the same cycle.
  - Next state S_A, `a_reg` = 0, `disp_mode` unchanged. A mode press in ERR toggles `disp_mode`.
- **Reset mid-EXEC:** `rst_n` low for 1 cycle while EXEC waits; ALU valid arrives afterwards.
  - State S_A, all outputs 0, late valid ignored.
